// File: rtl/overlay_img_buffer.sv
// Ping-pong 128x128 overlay sprite buffer: the loader fills the back bank while the display reads
// the front bank, and banks swap only on i_frame_start. Optional build macro: OVERLAY_IMG_TEST_PATTERN_EN.
module overlay_img_buffer #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 24
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [ADDR_W-1:0] i_req_addr,
   output logic [DATA_W-1:0] o_img_data,
   input  logic              i_frame_start,
   input  logic              i_load_start,
   input  logic              i_load_abort,
   input  logic              i_pix_valid,
   input  logic [DATA_W-1:0] i_pix_data,
   output logic              o_pix_ready,
   output logic              o_load_busy,
   output logic              o_load_done,
   output logic              o_bank
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PEND = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic              bank_q, bank_d;
   logic              img_valid_q, img_valid_d;
   logic              done_q, done_d;

   logic              pix_ready;
   logic              load_busy;
   logic              wr_en;
   logic              swap;

   logic [DATA_W-1:0] mem0 [DEPTH];
   logic [DATA_W-1:0] mem1 [DEPTH];
   logic [DATA_W-1:0] rd0_q, rd1_q;
   logic              rd_sel_q;
   logic              rd_valid_q;
   logic [DATA_W-1:0] fill_data;

   // Loader handshake: a pixel transfers on a cycle where i_pix_valid and o_pix_ready are both
   // high; i_pix_valid while o_pix_ready is low is dropped, not held. i_load_abort kills it.

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (i_load_start && !i_load_abort) state_d = ST_LOAD;
         ST_LOAD: begin
            if (i_load_abort)                state_d = ST_IDLE;
            else if (wr_en && (&wr_addr_q)) state_d = ST_PEND;
         end
         ST_PEND: if (i_load_abort || swap) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pix_ready = 1'b0;
      load_busy = 1'b0;
      wr_en     = 1'b0;
      swap      = 1'b0;
      unique case (state_q)
         ST_LOAD: begin
            pix_ready = 1'b1;
            load_busy = 1'b1;
            wr_en     = i_pix_valid && !i_load_abort;
         end
         ST_PEND: begin
            load_busy = 1'b1;
            swap      = i_frame_start && !i_load_abort;
         end
         default: ;
      endcase
   end

   always_comb begin
      wr_addr_d = wr_addr_q;
      if (state_q == ST_IDLE && i_load_start) begin
         wr_addr_d = '0;
      end else if (state_q != ST_IDLE && i_load_abort) begin
         wr_addr_d = '0;
      end else if (wr_en) begin
         wr_addr_d = wr_addr_q + ADDR_W'(1);
      end
      bank_d      = bank_q ^ swap;
      img_valid_d = img_valid_q | swap;
      done_d      = swap;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_addr_q   <= '0;
         bank_q      <= 1'b0;
         img_valid_q <= 1'b0;
         done_q      <= 1'b0;
         rd_sel_q    <= 1'b0;
         rd_valid_q  <= 1'b0;
      end else begin
         wr_addr_q   <= wr_addr_d;
         bank_q      <= bank_d;
         img_valid_q <= img_valid_d;
         done_q      <= done_d;
         // Captured with the pre-swap bank so a request at the swap edge still sees the old image
         rd_sel_q    <= bank_q;
         rd_valid_q  <= img_valid_q;
      end
   end

   // The back bank is always ~bank_q, so the write and read ports never share a bank.
   always_ff @(posedge i_clk) begin
      if (wr_en && bank_q) mem0[wr_addr_q] <= i_pix_data;
      rd0_q <= mem0[i_req_addr];
   end

   always_ff @(posedge i_clk) begin
      if (wr_en && !bank_q) mem1[wr_addr_q] <= i_pix_data;
      rd1_q <= mem1[i_req_addr];
   end

`ifdef OVERLAY_IMG_TEST_PATTERN_EN
   logic [DATA_W-1:0] pat_q;

   // 16x16 checkerboard: column bit 4 against row bit 4 (address bit 11)
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pat_q <= '0;
      end else begin
         pat_q <= (i_req_addr[4] ^ i_req_addr[11]) ? {DATA_W{1'b1}} : DATA_W'(8'hFF);
      end
   end

   assign fill_data = pat_q;
`else
   assign fill_data = '0;
`endif

   assign o_img_data  = rd_valid_q ? (rd_sel_q ? rd1_q : rd0_q) : fill_data;
   assign o_pix_ready = pix_ready;
   assign o_load_busy = load_busy;
   assign o_load_done = done_q;
   assign o_bank      = bank_q;

endmodule

// File: tb/tb_overlay_img_buffer.sv
// Bench for overlay_img_buffer: random reads and loader traffic against an image-level reference
// model; a monitor pops expected {done,bank,busy,ready,data} words and compares every cycle.
module tb_overlay_img_buffer;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 24;
   localparam int DEPTH  = 16384;
   localparam int EXP_W  = DATA_W + 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [DATA_W-1:0] img_data;
   logic              frame_start = 1'b0;
   logic              load_start = 1'b0;
   logic              load_abort = 1'b0;
   logic              pix_valid = 1'b0;
   logic [DATA_W-1:0] pix_data = '0;
   logic              pix_ready;
   logic              load_busy;
   logic              load_done;
   logic              bank;

   always #5 clk = ~clk;

   overlay_img_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_req_addr    (req_addr),
      .o_img_data    (img_data),
      .i_frame_start (frame_start),
      .i_load_start  (load_start),
      .i_load_abort  (load_abort),
      .i_pix_valid   (pix_valid),
      .i_pix_data    (pix_data),
      .o_pix_ready   (pix_ready),
      .o_load_busy   (load_busy),
      .o_load_done   (load_done),
      .o_bank        (bank)
   );

   // Reference model: the displayed image, the image being assembled, and a load phase
   // (0 = no load, 1 = accepting pixels, 2 = complete and waiting for a frame start).
   logic [DATA_W-1:0] shown_img [DEPTH];
   logic [DATA_W-1:0] load_img  [DEPTH];
   logic              shown_valid;
   logic              m_bank;
   int                phase;
   int                wcount;

   logic [EXP_W-1:0]  exp_q[$];
   logic [EXP_W-1:0]  mon_e;
   int                n_checks = 0;
   int                n_pass = 0;
   logic              use_fixed = 1'b0;
   logic [ADDR_W-1:0] fixed_addr = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [DATA_W-1:0] blank_val(input logic [ADDR_W-1:0] a);
`ifdef OVERLAY_IMG_TEST_PATTERN_EN
      return (a[4] ^ a[11]) ? 24'hFFFFFF : 24'h0000FF;
`else
      return (a === a) ? 24'h000000 : 24'h000000;
`endif
   endfunction

   task automatic model_reset();
      phase       = 0;
      wcount      = 0;
      shown_valid = 1'b0;
      m_bank      = 1'b0;
   endtask

   // One clock: drive at the falling edge, predict the post-edge outputs, then advance.
   task automatic cycle(input logic start, input logic abort, input logic valid, input logic fs,
                        input int mode);
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic [DATA_W-1:0] exp_d;
      logic              done;
      a = use_fixed ? fixed_addr : ADDR_W'($urandom_range(0, DEPTH - 1));
      if (phase == 1) d = (mode == 1) ? ~DATA_W'(wcount) : DATA_W'(wcount);
      else            d = DATA_W'($urandom);
      req_addr    = a;
      load_start  = start;
      load_abort  = abort;
      pix_valid   = valid;
      frame_start = fs;
      pix_data    = d;

      exp_d = shown_valid ? shown_img[a] : blank_val(a);
      done  = 1'b0;
      case (phase)
         0: if (start && !abort) begin
            phase  = 1;
            wcount = 0;
         end
         1: if (abort) begin
            phase  = 0;
            wcount = 0;
         end else if (valid) begin
            load_img[wcount] = d;
            wcount++;
            if (wcount == DEPTH) begin
               wcount = 0;
               phase  = 2;
            end
         end
         2: if (abort) begin
            phase = 0;
         end else if (fs) begin
            for (int i = 0; i < DEPTH; i++) shown_img[i] = load_img[i];
            shown_valid = 1'b1;
            m_bank      = ~m_bank;
            done        = 1'b1;
            phase       = 0;
         end
         default: phase = 0;
      endcase
      exp_q.push_back({done, m_bank, (phase != 0), (phase == 1), exp_d});

      @(posedge clk);
      @(negedge clk);
      load_start  = 1'b0;
      load_abort  = 1'b0;
      pix_valid   = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic stream(input int mode, input int pct, input int n_xfers);
      int got;
      got = 0;
      while (got < n_xfers) begin
         logic v;
         v = ($urandom_range(1, 100) <= pct);
         cycle(1'b0, 1'b0, v, 1'b0, mode);
         if (v) got++;
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (rst_n && exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("scoreboard", {4'b0, load_done, bank, load_busy, pix_ready, img_data}, {4'b0, mon_e});
      end
   end

   task automatic check_flags(input string tag, input logic e_ready, input logic e_busy,
                              input logic e_done, input logic e_bank);
      check({tag, "_ready"}, 32'(pix_ready), 32'(e_ready));
      check({tag, "_busy"},  32'(load_busy), 32'(e_busy));
      check({tag, "_done"},  32'(load_done), 32'(e_done));
      check({tag, "_bank"},  32'(bank),      32'(e_bank));
   endtask

   task automatic read_fixed(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e,
                             input logic valid, input int mode);
      use_fixed  = 1'b1;
      fixed_addr = a;
      cycle(1'b0, 1'b0, valid, 1'b0, mode);
      check(tag, 32'(img_data), 32'(e));
      use_fixed  = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("rst_img_data", 32'(img_data), 32'h0);
      check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      read_fixed("rst_read5", 14'd5, blank_val(14'd5), 1'b0, 0);

      // Abort alone and start+abort in IDLE both leave the buffer idle; stray valid is ignored
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 0);
      check_flags("idle_abort", 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);

      // First image: data = address, ragged valid
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
      check_flags("l1_start", 1'b1, 1'b1, 1'b0, 1'b0);
      stream(0, 60, DEPTH);
      check_flags("l1_pend", 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);
      check_flags("l1_wait", 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 0);
      check_flags("l1_swap", 1'b0, 1'b0, 1'b1, 1'b1);
      read_fixed("l1_read1234", 14'h1234, 24'h001234, 1'b0, 0);
      check("l1_done_once", 32'(load_done), 32'h0);

      // Second image (~address): start mid-load ignored, front stable, final pixel with frame start
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1);
      stream(1, 100, 8000);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1);
      read_fixed("l2_front_stable", 14'h1234, 24'h001234, 1'b1, 1);
      stream(1, 100, DEPTH - 8003);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1);
      check_flags("l2_coincident", 1'b0, 1'b1, 1'b0, 1'b1);
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1);
      check_flags("l2_swap", 1'b0, 1'b0, 1'b1, 1'b0);
      read_fixed("l2_read1234", 14'h1234, 24'hFFEDCB, 1'b0, 1);

      // Abort after 99 pixels, with a same-cycle pixel that must be dropped
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
      stream(0, 50, 99);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 0);
      check_flags("abort_load", 1'b0, 1'b0, 1'b0, 1'b0);
      read_fixed("abort_front", 14'h1234, 24'hFFEDCB, 1'b0, 0);

      // Full load restarts at address 0; abort beats frame start in PEND
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
      stream(0, 100, DEPTH);
      check_flags("l3_pend", 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
      check_flags("l3_start_ign", 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 0);
      check_flags("l3_abort_fs", 1'b0, 1'b0, 1'b0, 1'b0);
      read_fixed("l3_front", 14'h1234, 24'hFFEDCB, 1'b0, 0);

      // Asynchronous reset in the middle of a load
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
      stream(0, 100, 500);
      #2 rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("arst_img_data", 32'(img_data), 32'h0);
      check_flags("arst", 1'b0, 1'b0, 1'b0, 1'b0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      read_fixed("post_rst_read", 14'h1234, blank_val(14'h1234), 1'b0, 0);
      repeat (20) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Recovery load after reset
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
      stream(0, 100, DEPTH);
      read_fixed("l4_pend_read", 14'h1234, blank_val(14'h1234), 1'b0, 0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 0);
      check_flags("l4_swap", 1'b0, 1'b0, 1'b1, 1'b1);
      read_fixed("l4_read1234", 14'h1234, 24'h001234, 1'b0, 0);
      repeat (50) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);

      @(posedge clk);
      #2;
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
